// File: rtl/dbg_state_log_arbiter.sv
// Debug/power-state change logger: detects level changes on NUM_CH bits, round-robins them
// into a show-ahead event FIFO. Define DBG_LOG_TS_EN to keep per-event timestamps.
module dbg_state_log_arbiter #(
    parameter int NUM_CH     = 8,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iEnable,
    input  logic                      iClear,
    input  logic [NUM_CH-1:0]         iDbgSt,
    input  logic                      iLogRdEn,
    output logic                      oLogValid,
    output logic [$clog2(NUM_CH)-1:0] oLogCh,
    output logic                      oLogPrev,
    output logic                      oLogCurr,
    output logic [TS_W-1:0]           oLogTs,
    output logic                      oFifoFull,
    output logic                      oOverflow
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic                  rstAny;
    logic [NUM_CH-1:0]     cur;
    logic [NUM_CH-1:0]     pend;
    logic [NUM_CH-1:0]     evPrev;
    logic [NUM_CH-1:0]     evCurr;
    logic [NUM_CH-1:0]     chg;
    logic [NUM_CH-1:0]     capture;
    logic [NUM_CH-1:0]     coalesce;
    logic [NUM_CH-1:0]     grantVec;
    logic [CH_W-1:0]       rrPtr;
    logic [CH_W-1:0]       grantIdx;
    logic                  grantValid;
    logic                  doPush;
    logic                  doPop;
    logic                  fifoEmpty;
    logic [AW:0]           wrPtr;
    logic [AW:0]           rdPtr;
    logic [CH_W-1:0]       memCh [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] memPrev;
    logic [FIFO_DEPTH-1:0] memCurr;

    assign rstAny = iRst | iClear;

    // A change opens a fresh event when the channel is idle or is being drained this edge;
    // otherwise it folds into the pending one and only the final level survives.
    assign chg      = iDbgSt ^ cur;
    assign capture  = chg & {NUM_CH{iEnable}} & (~pend | grantVec);
    assign coalesce = chg & {NUM_CH{iEnable}} & pend & ~grantVec;

    // NOTE: every variable driven here gets a default first, so no path infers a latch.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        // Scan from the farthest offset down so the nearest pending channel wins.
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            logic [CH_W-1:0] idx;
            idx = CH_W'((int'(rrPtr) + off) % NUM_CH);
            if (pend[idx]) begin
                grantValid = 1'b1;
                grantIdx   = idx;
            end
        end
    end

    assign fifoEmpty = (wrPtr == rdPtr);
    assign oFifoFull = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop     = iLogRdEn & ~fifoEmpty;
    assign doPush    = grantValid & (~oFifoFull | doPop);

    always_comb begin
        grantVec = '0;
        if (doPush) grantVec[grantIdx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClk) begin
        if (rstAny) begin
            cur       <= iDbgSt;
            pend      <= '0;
            evPrev    <= '0;
            evCurr    <= '0;
            oOverflow <= 1'b0;
        end else begin
            cur    <= iDbgSt;
            pend   <= (pend & ~grantVec) | capture;
            evPrev <= (evPrev & ~capture) | (cur & capture);
            evCurr <= (evCurr & ~(capture | coalesce)) | (iDbgSt & (capture | coalesce));
            if (|coalesce) oOverflow <= 1'b1;
        end
    end

    // NOTE: storage is reset too, so the show-ahead outputs read 0 after reset/clear.
    always_ff @(posedge iClk) begin
        if (rstAny) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            rrPtr   <= '0;
            memPrev <= '0;
            memCurr <= '0;
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                memCh[j] <= '0;
            end
        end else begin
            if (doPop) rdPtr <= rdPtr + (AW+1)'(1);
            if (doPush) begin
                memCh[wrPtr[AW-1:0]]   <= grantIdx;
                memPrev[wrPtr[AW-1:0]] <= evPrev[grantIdx];
                memCurr[wrPtr[AW-1:0]] <= evCurr[grantIdx];
                wrPtr                  <= wrPtr + (AW+1)'(1);
                rrPtr                  <= (grantIdx == LAST_CH) ? '0 : grantIdx + CH_W'(1);
            end
        end
    end

    assign oLogValid = ~fifoEmpty;
    assign oLogCh    = memCh[rdPtr[AW-1:0]];
    assign oLogPrev  = memPrev[rdPtr[AW-1:0]];
    assign oLogCurr  = memCurr[rdPtr[AW-1:0]];

`ifdef DBG_LOG_TS_EN
    logic [TS_W-1:0] tsCnt;
    logic [TS_W-1:0] evTs  [NUM_CH];
    logic [TS_W-1:0] memTs [FIFO_DEPTH];

    always_ff @(posedge iClk) begin
        if (rstAny) tsCnt <= '0;
        else        tsCnt <= tsCnt + TS_W'(1);
    end

    always_ff @(posedge iClk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rstAny)          evTs[i] <= '0;
            else if (capture[i]) evTs[i] <= tsCnt;
        end
    end

    always_ff @(posedge iClk) begin
        if (rstAny) begin
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                memTs[j] <= '0;
            end
        end else if (doPush) begin
            memTs[wrPtr[AW-1:0]] <= evTs[grantIdx];
        end
    end

    assign oLogTs = memTs[rdPtr[AW-1:0]];
`else
    assign oLogTs = '0;
`endif

endmodule

// File: tb/tb_dbg_state_log_arbiter.sv
// Randomized + directed bench for dbg_state_log_arbiter against a queue-based event-log model.
module tb_dbg_state_log_arbiter;
    localparam int NUM_CH     = 8;
    localparam int TS_W       = 16;
    localparam int FIFO_DEPTH = 16;

    logic              iClk = 1'b0;
    logic              iRst, iEnable, iClear, iLogRdEn;
    logic [NUM_CH-1:0] iDbgSt;
    logic              oLogValid, oLogPrev, oLogCurr, oFifoFull, oOverflow;
    logic [2:0]        oLogCh;
    logic [TS_W-1:0]   oLogTs;

    int nTests = 0;
    int nFail  = 0;

    typedef struct {
        int ch;
        bit prev;
        bit curr;
        int ts;
    } ev_t;

    // Model: pending event per channel plus an ordered log of pushed events.
    ev_t q[$];
    bit  mCur    [NUM_CH];
    bit  mPend   [NUM_CH];
    bit  mPrev   [NUM_CH];
    bit  mCurrSt [NUM_CH];
    int  mTs     [NUM_CH];
    int  mRr, mTime;
    bit  mOvf;

    dbg_state_log_arbiter #(.NUM_CH(NUM_CH), .TS_W(TS_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .iClk(iClk), .iRst(iRst), .iEnable(iEnable), .iClear(iClear), .iDbgSt(iDbgSt),
        .iLogRdEn(iLogRdEn), .oLogValid(oLogValid), .oLogCh(oLogCh), .oLogPrev(oLogPrev),
        .oLogCurr(oLogCurr), .oLogTs(oLogTs), .oFifoFull(oFifoFull), .oOverflow(oOverflow)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int expTs(input int t);
`ifdef DBG_LOG_TS_EN
        return t;
`else
        return 0;
`endif
    endfunction

    task automatic modelEdge();
        bit pop;
        int g;
        int c;
        if (iRst || iClear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mCur[i]  = iDbgSt[i];
                mPend[i] = 1'b0;
            end
            q.delete();
            mRr = 0; mTime = 0; mOvf = 1'b0;
        end else begin
            pop = iLogRdEn && (q.size() != 0);
            g = -1;
            for (int off = 0; off < NUM_CH; off++) begin
                c = (mRr + off) % NUM_CH;
                if (mPend[c] && g < 0) g = c;
            end
            if (g >= 0 && !(q.size() < FIFO_DEPTH || pop)) g = -1;
            if (pop) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back('{g, mPrev[g], mCurrSt[g], mTs[g]});
                mRr = (g + 1) % NUM_CH;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (i == g) mPend[i] = 1'b0;
                if (iDbgSt[i] != mCur[i]) begin
                    if (iEnable) begin
                        if (!mPend[i]) begin
                            mPend[i] = 1'b1; mPrev[i] = mCur[i]; mTs[i] = mTime;
                        end else begin
                            mOvf = 1'b1;
                        end
                        mCurrSt[i] = iDbgSt[i];
                    end
                    mCur[i] = iDbgSt[i];
                end
            end
            mTime = (mTime + 1) % (1 << TS_W);
        end
    endtask

    task automatic compareAll();
        check("valid", oLogValid, q.size() != 0);
        check("full", oFifoFull, q.size() == FIFO_DEPTH);
        check("ovf", oOverflow, mOvf);
        if (q.size() != 0) begin
            check("head_ch", oLogCh, q[0].ch);
            check("head_prev", oLogPrev, q[0].prev);
            check("head_curr", oLogCurr, q[0].curr);
            check("head_ts", oLogTs, expTs(q[0].ts));
        end
    endtask

    task automatic step();
        @(posedge iClk);
        modelEdge();
        #1;
        compareAll();
    endtask

    task automatic doReset(input logic [NUM_CH-1:0] din);
        iRst = 1'b1; iClear = 1'b0; iEnable = 1'b1; iLogRdEn = 1'b0; iDbgSt = din;
        step();
        iRst = 1'b0;
        check("rst_ch", oLogCh, 0);
        check("rst_prev", oLogPrev, 0);
        check("rst_curr", oLogCurr, 0);
        check("rst_ts", oLogTs, 0);
    endtask

    task automatic drain(input string tag);
        iLogRdEn = 1'b1;
        for (int k = 0; k < 64 && oLogValid; k++) step();
        iLogRdEn = 1'b0;
        check(tag, oLogValid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int expOrder[8] = '{5, 6, 7, 0, 1, 2, 3, 4};
        int firstTs;
        int seen;
        int rdPct;

        iRst = 1'b1; iClear = 1'b0; iEnable = 1'b0; iLogRdEn = 1'b0; iDbgSt = '0;

        // Quiet inputs after reset: nothing logged.
        doReset(8'h05);
        for (int k = 0; k < 100; k++) step();
        check("t1_valid", oLogValid, 0);
        check("t1_ovf", oOverflow, 0);

        // Single rising edge on ch3 with timestamp 0x10.
        doReset(8'h05);
        for (int k = 0; k < 16; k++) step();
        iDbgSt[3] = 1'b1;
        step();
        check("t2_lat1", oLogValid, 0);
        step();
        check("t2_valid", oLogValid, 1);
        check("t2_ch", oLogCh, 3);
        check("t2_prev", oLogPrev, 0);
        check("t2_curr", oLogCurr, 1);
        check("t2_ts", oLogTs, expTs(16'h0010));
        iLogRdEn = 1'b1;
        step();
        iLogRdEn = 1'b0;
        check("t2_pop", oLogValid, 0);

        // All channels toggle together with the round-robin pointer at 5.
        doReset(8'h00);
        iDbgSt[4] = 1'b1;
        step();
        step();
        iLogRdEn = 1'b1;
        step();
        iLogRdEn = 1'b0;
        iDbgSt = ~iDbgSt;
        step();
        for (int k = 0; k < 8; k++) step();
        iLogRdEn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t3_order", oLogCh, expOrder[k]);
            step();
        end
        iLogRdEn = 1'b0;
        check("t3_empty", oLogValid, 0);

        // Twenty events without pops: FIFO fills, remainder back-pressured.
        doReset(8'h00);
        for (int t = 0; t < 20; t++) begin
            iDbgSt[t % 8] = ~iDbgSt[t % 8];
            step();
        end
        iDbgSt = iDbgSt;
        step();
        check("t4_full", oFifoFull, 1);
        check("t4_ovf", oOverflow, 0);
        iLogRdEn = 1'b1;
        step();
        iLogRdEn = 1'b0;
        check("t4_full_after_pop", oFifoFull, 1);
        drain("t4_drained");
        check("t4_ovf_end", oOverflow, 0);

        // ch1 toggles twice while stuck behind a full FIFO: coalesced into one entry.
        doReset(8'h00);
        for (int t = 0; t < 16; t++) begin
            iDbgSt[2 + t % 6] = ~iDbgSt[2 + t % 6];
            step();
        end
        step();
        check("t5_full", oFifoFull, 1);
        firstTs = mTime;
        iDbgSt[1] = 1'b1;
        step();
        iDbgSt[1] = 1'b0;
        step();
        check("t5_ovf", oOverflow, 1);
        seen = 0;
        iLogRdEn = 1'b1;
        for (int k = 0; k < 64 && oLogValid; k++) begin
            if (oLogCh == 3'd1) begin
                seen++;
                check("t5_prev", oLogPrev, 0);
                check("t5_curr", oLogCurr, 0);
                check("t5_ts", oLogTs, expTs(firstTs));
            end
            step();
        end
        iLogRdEn = 1'b0;
        check("t5_single", seen, 1);
        check("t5_ovf_sticky", oOverflow, 1);
        iClear = 1'b1;
        step();
        iClear = 1'b0;
        check("t5_ovf_clr", oOverflow, 0);

        // Clear with entries queued and a disabled toggle on ch2 in the same edge.
        doReset(8'h00);
        for (int t = 0; t < 6; t++) begin
            iDbgSt[t] = 1'b1;
            step();
        end
        step();
        check("t6_full_cnt", oLogValid, 1);
        iClear = 1'b1; iEnable = 1'b0; iDbgSt[2] = ~iDbgSt[2];
        step();
        check("t6_cleared", oLogValid, 0);
        iClear = 1'b0; iEnable = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check("t6_no_ch2", oLogValid, 0);

        // Randomized traffic against the model.
        doReset(NUM_CH'($urandom));
        rdPct = 40;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 256 == 0) rdPct = $urandom_range(5, 80);
            iRst     = ($urandom_range(0, 499) == 0);
            iClear   = ($urandom_range(0, 299) == 0);
            iEnable  = ($urandom_range(0, 3) != 0);
            iLogRdEn = ($urandom_range(0, 99) < rdPct);
            for (int b = 0; b < NUM_CH; b++) begin
                if ($urandom_range(0, 5) == 0) iDbgSt[b] = ~iDbgSt[b];
            end
            step();
        end
        iRst = 1'b0; iClear = 1'b0; iEnable = 1'b0;
        drain("rand_drained");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
